// File: rtl/xor_tree_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// xor_tree_pipe
//
// Pipelined, parametrised XOR reduction of NUM_VEC vectors of WIDTH bits.
// Each vector is first gated by its mask bit. The gated vectors are then
// reduced through a balanced binary tree, with a register stage after every
// tree level. Stages move data with a valid/ready handshake. A stage accepts
// new data whenever it is empty or its successor is accepting, so bubbles
// collapse even while the output is stalled.
//
// Ports
//   i_clk         : clock, all state changes on the rising edge
//   i_rst         : synchronous active-high reset, clears all stages
//   i_in_vectors  : NUM_VEC*WIDTH concatenated vectors, vector 0 in the LSBs
//   i_in_mask     : per-vector enable, 0 replaces that vector with zero
//   i_in_valid    : an input transaction is present
//   o_in_ready    : the input is accepted this cycle
//   o_out_xor     : XOR of the masked vectors of the oldest transaction
//   o_out_valid   : o_out_xor holds a result
//   i_out_ready   : the consumer takes the result this cycle
// -----------------------------------------------------------------------------
module xor_tree_pipe #(
  parameter int NUM_VEC = 5,
  parameter int WIDTH   = 31
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_VEC*WIDTH-1:0] i_in_vectors,
  input  logic [NUM_VEC-1:0]       i_in_mask,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic [WIDTH-1:0]         o_out_xor,
  output logic                     o_out_valid,
  input  logic                     i_out_ready
);

  // One register stage per tree level; a single vector still gets one stage.
  localparam int DEPTH = (NUM_VEC <= 32'sd1) ? 32'sd1 : $clog2(NUM_VEC);

  // Number of elements present at a given tree level (level 0 = inputs).
  function automatic int level_count(input int level);
    int n;
    n = NUM_VEC;
    for (int k = 0; k < level; k++) begin
      n = (n + 32'sd1) / 32'sd2;
    end
    return n;
  endfunction

  logic [NUM_VEC*WIDTH-1:0] w_level0;
  logic [DEPTH-1:0]         w_valid;
  logic [DEPTH-1:0]         w_en;

  // Gate each input vector with its mask bit ahead of the first stage.
  always_comb begin
    w_level0 = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (i_in_mask[i]) begin
        w_level0[i*WIDTH +: WIDTH] = i_in_vectors[i*WIDTH +: WIDTH];
      end else begin
        w_level0[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // Stage k may load when the consumer is ready or any stage from k to the
  // output is empty; written without a chained vector so no comb loop forms.
  always_comb begin
    w_en = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_en[k] = i_out_ready;
      for (int j = k; j < DEPTH; j++) begin
        w_en[k] = w_en[k] | ~w_valid[j];
      end
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    localparam int N_IN  = level_count(s);
    localparam int N_OUT = level_count(s + 32'sd1);

    logic [N_IN*WIDTH-1:0]  w_src;
    logic                   w_vin;
    logic [N_OUT*WIDTH-1:0] w_next;
    logic [N_OUT*WIDTH-1:0] r_data;
    logic                   r_valid;

    if (s == 32'sd0) begin : g_first
      assign w_src = w_level0;
      assign w_vin = i_in_valid;
    end else begin : g_inner
      assign w_src = g_stage[s-1].r_data;
      assign w_vin = g_stage[s-1].r_valid;
    end

    // Pairwise XOR of adjacent elements; an odd trailing element is
    // forwarded unchanged to keep the tree balanced.
    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      if ((32'sd2 * j + 32'sd1) < N_IN) begin : g_xor
        assign w_next[j*WIDTH +: WIDTH] =
          w_src[(32'sd2*j)*WIDTH +: WIDTH] ^ w_src[(32'sd2*j + 32'sd1)*WIDTH +: WIDTH];
      end else begin : g_pass
        assign w_next[j*WIDTH +: WIDTH] = w_src[(32'sd2*j)*WIDTH +: WIDTH];
      end
    end

    // Stage register: reset clears data and valid, otherwise load on enable.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_en[s]) begin
        r_data  <= w_next;
        r_valid <= w_vin;
      end else begin
        r_data  <= r_data;
        r_valid <= r_valid;
      end
    end

    assign w_valid[s] = r_valid;
  end

  // in_ready is combinational from out_ready; there is no skid buffer.
  assign o_in_ready  = w_en[0];
  assign o_out_valid = w_valid[DEPTH-1];
  assign o_out_xor   = g_stage[DEPTH-1].r_data;

endmodule

// File: tb/tb_xor_tree_pipe.sv
`timescale 1ns/1ps
module tb_xor_tree_pipe;
  localparam int NV = 5;
  localparam int W  = 31;
  localparam int D  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NV*W-1:0] in_vectors;
  logic [NV-1:0]   in_mask;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_xor;
  logic            out_valid;
  logic            out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  xor_tree_pipe #(.NUM_VEC(NV), .WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_vectors (in_vectors),
    .i_in_mask    (in_mask),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_out_xor    (out_xor),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_xor(input logic [NV*W-1:0] v, input logic [NV-1:0] m);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NV; i++) if (m[i]) acc ^= v[i*W +: W];
    return acc;
  endfunction

  // ---------------- reference model: ordered queue with transit time ------
  logic [W-1:0] q_val[$];
  int           q_acc[$];
  int  cyc = 0;
  int  last_dep = 0;
  int  n_in = 0, n_out = 0, n_drop = 0;
  bit  mdl_en = 1'b0;
  bit  rst_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mdl_en) begin : cmp
      bit exp_v;
      bit exp_rdy;
      int arr;
      exp_v = 1'b0;
      if (q_val.size() > 0) begin
        arr = q_acc[0] + D - 1;
        if (last_dep > arr) arr = last_dep;
        exp_v = (arr <= cyc);
      end
      exp_rdy = (q_val.size() < D) || out_ready;
      check("out_valid", out_valid, exp_v);
      check("in_ready", in_ready, exp_rdy);
      if (exp_v) check("out_xor", out_xor, q_val[0]);
      if (rst_seen) begin
        check("reset_xor", out_xor, 64'd0);
        rst_seen = 1'b0;
      end
      if (rst) begin
        n_drop += q_val.size();
        q_val.delete();
        q_acc.delete();
        rst_seen = 1'b1;
      end else begin
        if (exp_v && out_ready) begin
          void'(q_val.pop_front());
          void'(q_acc.pop_front());
          last_dep = cyc + 1;
          n_out++;
        end
        if (in_valid && exp_rdy) begin
          q_val.push_back(ref_xor(in_vectors, in_mask));
          q_acc.push_back(cyc + 1);
          n_in++;
        end
      end
    end
  end

  // ---------------- helpers ----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vecs(input logic [W-1:0] a, b, c, d, e);
    in_vectors = {e, d, c, b, a};
  endtask

  task automatic wait_out(input string name, input logic [W-1:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({name, "_valid"}, out_valid, 64'd1);
    check(name, out_xor, exp);
    tick();
  endtask

  // ---------------- parameter sweep instances ----------------------------
  for (genvar g = 0; g < 5; g++) begin : g_sweep
    localparam int SNV = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 8 : 9;
    localparam int SW  = (g == 0) ? 31 : (g == 1) ? 1 : (g == 2) ? 64 : (g == 3) ? 31 : 64;
    localparam int SD  = (g == 0) ? 1 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 3 : 4;

    logic              s_rst;
    logic [SNV*SW-1:0] s_vec;
    logic [SNV-1:0]    s_mask;
    logic              s_iv, s_ir, s_ov, s_or;
    logic [SW-1:0]     s_xor;
    bit                done = 1'b0;

    xor_tree_pipe #(.NUM_VEC(SNV), .WIDTH(SW)) sdut (
      .i_clk        (clk),
      .i_rst        (s_rst),
      .i_in_vectors (s_vec),
      .i_in_mask    (s_mask),
      .i_in_valid   (s_iv),
      .o_in_ready   (s_ir),
      .o_out_xor    (s_xor),
      .o_out_valid  (s_ov),
      .i_out_ready  (s_or)
    );

    initial begin
      logic [SW-1:0] exp;
      int lat;
      s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b1; s_vec = '0; s_mask = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      s_rst = 1'b0;
      for (int it = 0; it < 12; it++) begin
        for (int b = 0; b < SNV*SW; b++) s_vec[b] = 1'($urandom());
        s_mask = (it == 0) ? '1 : SNV'($urandom());
        exp = '0;
        for (int i = 0; i < SNV; i++) if (s_mask[i]) exp ^= s_vec[i*SW +: SW];
        s_iv = 1'b1;
        @(negedge clk);
        check($sformatf("sweep%0d_in_ready", g), s_ir, 64'd1);
        @(posedge clk); #1;
        s_iv = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!s_ov && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("sweep%0d_latency", g), lat, SD);
        check($sformatf("sweep%0d_xor", g), s_xor, exp);
        @(posedge clk); #1;
      end
      done = 1'b1;
    end
  end

  // ---------------- watchdog ---------------------------------------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed + random stimulus ---------------------------
  logic [W-1:0] got[$];

  initial begin
    rst = 1'b1; in_vectors = '0; in_mask = '0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    mdl_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_xor", out_xor, 64'd0);
    check("rst_in_ready", in_ready, 64'd1);
    tick();

    // single transaction, latency 3, one-cycle pulse
    set_vecs(31'h1, 31'h2, 31'h4, 31'h8, 31'h10);
    in_mask = 5'b11111;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk); check("lat_edge0", out_valid, 64'd0);
    @(negedge clk); check("lat_edge1", out_valid, 64'd0);
    @(negedge clk); check("lat_edge2", out_valid, 64'd1);
    check("single_xor", out_xor, 64'h1F);
    @(negedge clk); check("pulse_len", out_valid, 64'd0);
    tick();

    // masking
    in_mask = 5'b00101; in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_out("mask_00101", 31'h05);
    set_vecs(31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'h7FFFFFFF);
    in_mask = 5'b11111; in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_out("all_ones", 31'h7FFFFFFF);
    set_vecs(31'h1, 31'h2, 31'h4, 31'h8, 31'h10);
    in_mask = 5'b00000; in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_out("mask_zero", 31'h0);
    set_vecs(31'h3, 31'h5, 31'h6, 31'h0, 31'h40);
    in_mask = 5'b10111; in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_out("odd_tail", 31'h40);

    // backpressure: three fill the pipe, the fourth waits
    out_ready = 1'b0;
    in_mask = 5'b00001;
    for (int k = 1; k <= 4; k++) begin
      set_vecs(31'(k), 31'h0, 31'h0, 31'h0, 31'h0);
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_in_ready", in_ready, (k <= 3) ? 64'd1 : 64'd0);
      if (k <= 3) tick();
    end
    check("bp_full_valid", out_valid, 64'd1);
    check("bp_full_xor", out_xor, 64'd1);
    tick();
    @(negedge clk);
    check("bp_hold_xor", out_xor, 64'd1);
    check("bp_hold_ready", in_ready, 64'd0);
    tick();
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_xor);
      tick();
      in_valid = 1'b0;
    end
    check("bp_count", got.size(), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", got[i], i + 1);

    // reset with two in flight and a handshake on the reset edge
    set_vecs(31'h1234, 31'h0, 31'h0, 31'h0, 31'h0);
    in_valid = 1'b1;
    tick();
    set_vecs(31'h5678, 31'h0, 31'h0, 31'h0, 31'h0);
    tick();
    set_vecs(31'h9ABC, 31'h0, 31'h0, 31'h0, 31'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rr_out_valid", out_valid, 64'd0);
    check("rr_out_xor", out_xor, 64'd0);
    check("rr_in_ready", in_ready, 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rr_no_ghost", out_valid, 64'd0);
    end
    tick();

    // random traffic with random stalls
    begin
      int budget;
      int target;
      budget = 0;
      target = n_in + 1000;
      while (n_in < target && budget < 20000) begin
        for (int i = 0; i < NV; i++) in_vectors[i*W +: W] = W'($urandom());
        in_mask   = NV'($urandom());
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
        tick();
        budget++;
      end
      check("rand_budget", (n_in >= target), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2 * D + 2) tick();
    check("count_io", n_out + n_drop, n_in);
    check("queue_empty", q_val.size(), 64'd0);

    begin
      int w;
      w = 0;
      while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
               g_sweep[3].done && g_sweep[4].done) && w < 2000) begin
        tick();
        w++;
      end
      check("sweep_done", (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                           g_sweep[3].done && g_sweep[4].done), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/xor_tree_pipe.md
# xor_tree_pipe

Parametrised, pipelined successor to the fixed 5×31 combinational XOR tree. Computes the bitwise XOR of NUM_VEC concatenated WIDTH-bit vectors through a balanced binary tree, with a register stage after every tree level. The block uses a valid/ready handshake with full backpressure and a per-transaction vector-enable mask. It sits between the GF(2^m) PRNG matrix-row selection logic and the state register, so a wide reduction can close timing at high clock rates.

## Interface

Parameters:
- NUM_VEC, 5: number of input vectors. Must be ≥ 1.
- WIDTH, 31: bit width of each vector. Must be ≥ 1.
- DEPTH (localparam): max(1, ceil(log2(NUM_VEC))); number of register stages. 3 for the defaults.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_vectors, input, NUM_VEC*WIDTH: concatenated vectors; vector i = in_vectors[i*WIDTH +: WIDTH]; vector 0 in the LSBs.
- in_mask, input, NUM_VEC: bit i = 1 includes vector i; bit i = 0 replaces vector i with zero.
- in_valid, input, 1: input transaction present.
- in_ready, output, 1: block accepts the input this cycle.
- out_xor, output, WIDTH: XOR of all masked vectors of the transaction.
- out_valid, output, 1: out_xor holds a result.
- out_ready, input, 1: the consumer accepts the result this cycle.

## Operation

- **Masking:** level 0 element i = in_mask[i] ? vector i : 0. Masking is combinational, before stage 1.
- **Tree:** level s+1 element j = level s element 2j XOR element 2j+1. An odd trailing element passes through unchanged. Each level is registered into stage s+1, together with a valid bit v_{s+1}.
- **NUM_VEC = 1:** DEPTH = 1. The single stage registers the masked vector.
- **Stage enables:** en_{DEPTH+1} = out_ready; en_k = !v_k || en_{k+1}. When en_k = 1:
  - data_k ← level k-1 result;
  - v_k ← v_{k-1}, with v_0 = in_valid.
- **Outputs:**
  - in_ready = en_1.
  - out_valid = v_DEPTH; out_xor = data_DEPTH.
- **Handshake:**
  - A transfer occurs on a cycle with valid && ready on the respective side.
  - in_ready is combinational from out_ready and the valid bits. This path is accepted; no skid buffer.
  - Bubbles collapse: an empty stage fills even while downstream stages stall.
  - Up to DEPTH transactions in flight. Order is preserved and no transaction is dropped or duplicated.
- **Stalls:** while stalled, out_xor and out_valid hold stable until out_ready is sampled high.
- **Don't-care inputs:** in_vectors and in_mask are ignored when in_valid = 0.
- **in_mask = 0:** result is all zeros. It is still a valid transaction.

## Timing

- **Reset:**
  - All v_k ← 0, so out_valid = 0 in the cycle after rst is sampled high.
  - All data_k ← 0, so out_xor = 0.
  - in_ready = 1 whenever not full. It is 1 on the first cycle after reset.
- **Reset mid-operation:** in-flight transactions are discarded. No out_valid pulse appears for them after reset.
- **Latency:** a transaction accepted at edge t appears with out_valid = 1 after edge t+DEPTH-1, i.e. DEPTH cycles from acceptance to visibility, provided there are no stalls. This is 3 cycles for the defaults.
- **Throughput:** 1 transaction/cycle while out_ready = 1.
- **Full:** all v_k = 1 and out_ready = 0 gives in_ready = 0.
- **Simultaneous full and drain:** when all stages are full and out_ready = 1, the output transfers and a new input is accepted in the same cycle.
- **Simultaneous reset and handshake:** rst takes priority over any handshake on the same edge.

## Test plan

- **Single transaction:**
  - Stimulus: defaults, vectors 0x1, 0x2, 0x4, 0x8, 0x10; mask 5'b11111; one-cycle in_valid; out_ready = 1.
  - Response: out_xor = 0x1F, with out_valid high exactly 3 cycles after acceptance, for 1 cycle.
- **Masking:**
  - Stimulus: the same vectors with mask 5'b00101.
  - Response: 0x05.
  - Stimulus: all vectors 0x7FFFFFFF with mask 5'b11111.
  - Response: 0x7FFFFFFF.
  - Stimulus: mask 0.
  - Response: 0x0 with out_valid = 1.
- **Backpressure:**
  - Stimulus: out_ready = 0; stream transactions with distinct values 1, 2, 3, 4.
  - Response: 3 transfers accepted; in_ready = 0 on the 4th; out_xor is held stable. Releasing out_ready yields 1, 2, 3, 4 in order with no loss.
- **Back-to-back with random stalls:**
  - Stimulus: 1000 random transactions, random in_valid and out_ready.
  - Response: every output matches the reference XOR model, in order; count out = count in.
- **Reset mid-stream:**
  - Stimulus: assert rst with 2 transactions in flight.
  - Response: next cycle out_valid = 0, out_xor = 0, in_ready = 1; the discarded results never appear.
- **Parameter sweep:**
  - Stimulus: NUM_VEC ∈ {1, 2, 3, 8, 9}, WIDTH ∈ {1, 31, 64}.
  - Response: latency = DEPTH (1, 1, 2, 3, 4 respectively) and results match the model.
